// File: rtl/vending_if.sv
// Vending controller handshake bundle: coin/selection/cancel requests from the
// front panel (master) and the registered dispense/refund indications returned
// by the controller (slave).
interface vending_if #(
    parameter int unsigned NUM_PROD = 4,
    parameter int unsigned CREDIT_W = 6
);
    localparam int unsigned IdW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

    // Requests
    logic                coin_valid;
    logic [1:0]          coin_val;
    logic                sel_valid;
    logic [IdW-1:0]      sel_id;
    logic                cancel;

    // Indications
    logic                vend_valid;
    logic [IdW-1:0]      vend_id;
    logic                change_valid;
    logic                coin_reject;
    logic                sel_err;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_id, cancel,
        input  vend_valid, vend_id, change_valid, coin_reject, sel_err, credit, busy
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_id, cancel,
        output vend_valid, vend_id, change_valid, coin_reject, sel_err, credit, busy
    );
endinterface

// File: rtl/vending_ctrl.sv
// Vending machine controller: collects 5/10-unit coins into a credit register,
// dispenses a selected product when credit covers its price, and pays the
// remainder back one 5-unit coin per cycle. All outputs are registered.
// Optional feature macro: VENDING_STOCK_COUNT_EN adds per-product stock
// counters; without it every product is always in stock.
module vending_ctrl #(
    parameter int unsigned NUM_PROD   = 4,
    parameter int unsigned PRICE_STEP = 5,
    parameter int unsigned CREDIT_W   = 6,
    parameter int unsigned MAX_CREDIT = 40,
    parameter int unsigned STOCK_INIT = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    vending_if.slave bus
);

    localparam int unsigned IdW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam int unsigned CoinUnit = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StVend,
        StChange
    } state_e;

    state_e              state_q,        state_d;
    logic [CREDIT_W-1:0] credit_q,       credit_d;
    logic [IdW-1:0]      sel_q,          sel_d;
    logic                vend_valid_q,   vend_valid_d;
    logic [IdW-1:0]      vend_id_q,      vend_id_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q,  coin_reject_d;
    logic                sel_err_q,      sel_err_d;
    logic                busy_q,         busy_d;

    // Decoded request qualifiers
    int unsigned         coin_amt;
    logic                coin_ok;
    logic                id_in_range;
    logic                in_stock;
    logic                sel_ok;
    logic [CREDIT_W-1:0] vend_rem;

    function automatic int unsigned price_of(input logic [IdW-1:0] id);
        return (32'(id) + 32'd1) * PRICE_STEP;
    endfunction

`ifdef VENDING_STOCK_COUNT_EN
    localparam int unsigned StockW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [StockW-1:0] stock_q [NUM_PROD];
    logic [StockW-1:0] stock_d [NUM_PROD];

    // Stock lookup for the product currently being selected
    always_comb begin
        in_stock = 1'b0;
        if (id_in_range) begin
            in_stock = (stock_q[bus.sel_id] != '0);
        end
    end
`else
    // No stock tracking: the initial stock level has no meaning here.
    logic unused_stock_init;
    assign unused_stock_init = ^STOCK_INIT;
    assign in_stock = 1'b1;
`endif

    // Coin and selection qualification against the current credit
    always_comb begin
        unique case (bus.coin_val)
            2'b01:   coin_amt = 5;
            2'b10:   coin_amt = 10;
            default: coin_amt = 0;
        endcase
        coin_ok     = (coin_amt != 0) && ((32'(credit_q) + coin_amt) <= MAX_CREDIT);
        id_in_range = (32'(bus.sel_id) < NUM_PROD);
        sel_ok      = id_in_range && in_stock && (32'(credit_q) >= price_of(bus.sel_id));
        vend_rem    = credit_q - CREDIT_W'(price_of(sel_q));
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        vend_valid_d   = 1'b0;
        vend_id_d      = '0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        sel_err_d      = 1'b0;
`ifdef VENDING_STOCK_COUNT_EN
        stock_d        = stock_q;
`endif

        unique case (state_q)
            StIdle: begin
                // cancel is meaningless with no credit held
                if (bus.sel_valid) begin
                    sel_err_d = 1'b1;
                end
                if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = credit_q + CREDIT_W'(coin_amt);
                        state_d  = StCollect;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            StCollect: begin
                if (bus.cancel) begin
                    state_d       = StChange;
                    coin_reject_d = bus.coin_valid;
                end else if (bus.sel_valid) begin
                    coin_reject_d = bus.coin_valid;
                    if (sel_ok) begin
                        sel_d   = bus.sel_id;
                        state_d = StVend;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = credit_q + CREDIT_W'(coin_amt);
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            StVend: begin
                // Price was checked against credit on entry, so no underflow
                vend_valid_d  = 1'b1;
                vend_id_d     = sel_q;
                credit_d      = vend_rem;
                coin_reject_d = bus.coin_valid;
                state_d       = (vend_rem != '0) ? StChange : StIdle;
`ifdef VENDING_STOCK_COUNT_EN
                stock_d[sel_q] = stock_q[sel_q] - StockW'(1);
`endif
            end

            StChange: begin
                change_valid_d = 1'b1;
                coin_reject_d  = bus.coin_valid;
                if (32'(credit_q) > CoinUnit) begin
                    credit_d = credit_q - CREDIT_W'(CoinUnit);
                end else begin
                    credit_d = '0;
                    state_d  = StIdle;
                end
            end

            default: begin
                state_d  = StIdle;
                credit_d = '0;
            end
        endcase

        busy_d = (state_d == StVend) || (state_d == StChange);
    end

    // State and registered outputs; reset discards any credit still owed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            sel_q          <= '0;
            vend_valid_q   <= 1'b0;
            vend_id_q      <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            busy_q         <= 1'b0;
`ifdef VENDING_STOCK_COUNT_EN
            for (int unsigned i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= StockW'(STOCK_INIT);
            end
`endif
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            vend_valid_q   <= vend_valid_d;
            vend_id_q      <= vend_id_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            busy_q         <= busy_d;
`ifdef VENDING_STOCK_COUNT_EN
            stock_q        <= stock_d;
`endif
        end
    end

    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_id      = vend_id_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_err      = sel_err_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed, table-driven bench for vending_ctrl. Each table row is one clock
// cycle: the inputs applied before the edge and the registered outputs
// expected just after it. Reset behaviour is checked by hand-written steps.
module tb_vending_ctrl;

    logic clk;
    logic rst_n;

    vending_if #(.NUM_PROD(4), .CREDIT_W(6)) bus ();

    vending_ctrl #(
        .NUM_PROD  (4),
        .PRICE_STEP(5),
        .CREDIT_W  (6),
        .MAX_CREDIT(40),
        .STOCK_INIT(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cancel;
        logic       sel_valid;
        logic [1:0] sel_id;
        logic       coin_valid;
        logic [1:0] coin_val;
        logic       vend;
        logic [1:0] vend_id;
        logic       chg;
        logic       rej;
        logic       err;
        logic [5:0] credit;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic c, input logic s, input logic [1:0] id,
                                input logic cv, input logic [1:0] val, input logic ev,
                                input logic [1:0] eid, input logic ec, input logic er,
                                input logic ee, input logic [5:0] cr, input logic eb);
        vec_t v;
        v.cancel = c;  v.sel_valid = s;  v.sel_id = id;  v.coin_valid = cv;
        v.coin_val = val;  v.vend = ev;  v.vend_id = eid;  v.chg = ec;
        v.rej = er;  v.err = ee;  v.credit = cr;  v.busy = eb;
        return v;
    endfunction

    task automatic t(input logic c, input logic s, input logic [1:0] id, input logic cv,
                     input logic [1:0] val, input logic ev, input logic [1:0] eid,
                     input logic ec, input logic er, input logic ee, input logic [5:0] cr,
                     input logic eb);
        tbl.push_back(mk(c, s, id, cv, val, ev, eid, ec, er, ee, cr, eb));
    endtask

    // Refund rows for a credit of cr0: one 5-unit pulse per cycle down to 0
    task automatic chg_from(input int cr0);
        for (int c = cr0 - 5; c >= 0; c -= 5) begin
            t(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'(c), c != 0);
        end
    endtask

    task automatic check_out(input vec_t v, input string name);
        logic [12:0] act;
        logic [12:0] exp;
        act = {bus.vend_valid, bus.vend_id, bus.change_valid, bus.coin_reject, bus.sel_err,
               bus.credit, bus.busy};
        exp = {v.vend, v.vend_id, v.chg, v.rej, v.err, v.credit, v.busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got vend=%b id=%0d chg=%b rej=%b err=%b credit=%0d busy=%b, expected vend=%b id=%0d chg=%b rej=%b err=%b credit=%0d busy=%b",
                     name, bus.vend_valid, bus.vend_id, bus.change_valid, bus.coin_reject,
                     bus.sel_err, bus.credit, bus.busy, v.vend, v.vend_id, v.chg, v.rej,
                     v.err, v.credit, v.busy);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        bus.cancel     = v.cancel;
        bus.sel_valid  = v.sel_valid;
        bus.sel_id     = v.sel_id;
        bus.coin_valid = v.coin_valid;
        bus.coin_val   = v.coin_val;
        @(posedge clk);
        #1;
        check_out(v, name);
    endtask

    vec_t zero;
    logic stock_fail;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        bus.cancel = 1'b0;  bus.sel_valid = 1'b0;  bus.sel_id = '0;
        bus.coin_valid = 1'b0;  bus.coin_val = '0;

        // Coin 10 + coin 5, buy id 1 (price 10), one change pulse
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 10, 0);
        t(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 15, 0);
        t(0, 1, 1, 0, 0,     0, 0, 0, 0, 0, 15, 1);
        t(0, 0, 0, 0, 0,     1, 1, 0, 0, 0,  5, 1);
        t(0, 0, 0, 0, 0,     0, 0, 1, 0, 0,  0, 0);
        t(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0);
        // Idle: invalid coin rejected, selection refused, cancel ignored
        t(0, 0, 0, 1, 2'b11, 0, 0, 0, 1, 0,  0, 0);
        t(0, 1, 0, 0, 0,     0, 0, 0, 0, 1,  0, 0);
        t(1, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0);
        // Build 35, overflowing and invalid coins rejected, cancel -> 7 pulses
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 10, 0);
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 20, 0);
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 30, 0);
        t(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 35, 0);
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 1, 0, 35, 0);
        t(0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 0, 35, 0);
        t(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 35, 1);
        t(0, 0, 0, 1, 2'b10, 0, 0, 1, 1, 0, 30, 1);  // coin during change rejected
        t(0, 1, 0, 0, 0,     0, 0, 1, 0, 0, 25, 1);  // selection during change ignored
        chg_from(25);
        t(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0);
        // Exactly MAX_CREDIT accepted, one more coin rejected, 8-pulse refund
        for (int k = 1; k <= 4; k++) t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 6'(10 * k), 0);
        t(0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 0, 40, 0);
        t(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 40, 1);
        chg_from(40);
        // Credit 10, id 3 too expensive, then id 0 with one change pulse
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 10, 0);
        t(0, 1, 3, 0, 0,     0, 0, 0, 0, 1, 10, 0);
        t(0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 10, 1);
        t(0, 0, 0, 0, 0,     1, 0, 0, 0, 0,  5, 1);
        t(0, 0, 0, 0, 0,     0, 0, 1, 0, 0,  0, 0);
        // Cancel + select + coin together: cancel wins, coin rejected, 2 pulses
        t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 10, 0);
        t(1, 1, 0, 1, 2'b01, 0, 0, 0, 1, 0, 10, 1);
        chg_from(10);
        // Select + coin together: vend proceeds, coin rejected, exact credit -> idle
        t(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0,  5, 0);
        t(0, 1, 0, 1, 2'b01, 0, 0, 0, 1, 0,  5, 1);
        t(0, 0, 0, 0, 0,     1, 0, 0, 0, 0,  0, 0);
        t(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0);
        // Four exact-credit buys of id 2 (price 15)
        for (int b = 0; b < 4; b++) begin
`ifdef VENDING_STOCK_COUNT_EN
            stock_fail = (b == 3);
`else
            stock_fail = 1'b0;
`endif
            t(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 10, 0);
            t(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 15, 0);
            if (stock_fail) begin
                t(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 15, 0);
                t(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 1);
                chg_from(15);
            end else begin
                t(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 15, 1);
                t(0, 0, 0, 0, 0, 1, 2, 0, 0, 0,  0, 0);
            end
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_out(zero, "reset_state");
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // 20-unit refund interrupted by reset during the second pulse
        step(mk(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 10, 0), "rst_coin1");
        step(mk(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 20, 0), "rst_coin2");
        step(mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 20, 1), "rst_cancel");
        step(mk(0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 15, 1), "rst_chg1");
        step(mk(0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 10, 1), "rst_chg2");
        rst_n = 1'b0;
        #1;
        check_out(zero, "rst_async_clear");
        repeat (2) @(posedge clk);
        #1;
        check_out(zero, "rst_held");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(zero, $sformatf("rst_no_change%0d", k));
        // The first edge after release already accepts a coin
        step(mk(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 5, 0), "post_rst_coin");
        step(mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 5, 1), "post_rst_cancel");
        step(mk(0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0), "post_rst_chg");
        step(zero, "post_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 Parameter NUM_PROD, 4, number of selectable products (2..8).
REQ-002 Parameter PRICE_STEP, 5, price unit; price of product i = (i+1)*PRICE_STEP.
REQ-003 Parameter CREDIT_W, 6, width of credit register and credit output.
REQ-004 Parameter MAX_CREDIT, 40, highest credit accepted; must be a multiple of 5 and below 2**CREDIT_W.
REQ-005 Parameter STOCK_INIT, 3, per-product stock loaded at reset (STOCK_COUNT_EN only).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 coin_valid  input  1  coin inserted this cycle.
REQ-009 coin_val  input  2  01 = 5 units, 10 = 10 units; 00/11 are invalid coins.
REQ-010 sel_valid  input  1  product selection strobe.
REQ-011 sel_id  input  clog2(NUM_PROD)  selected product index.
REQ-012 cancel  input  1  abort; refund all credit.
REQ-013 vend_valid  output  1  one-cycle pulse, product dispensed.
REQ-014 vend_id  output  clog2(NUM_PROD)  product dispensed; valid with vend_valid.
REQ-015 change_valid  output  1  one-cycle pulse per 5-unit coin returned.
REQ-016 coin_reject  output  1  one-cycle pulse, coin returned unaccepted.
REQ-017 sel_err  output  1  one-cycle pulse, selection refused.
REQ-018 credit  output  CREDIT_W  current credit, registered.
REQ-019 busy  output  1  high in VEND and CHANGE.

Function
REQ-020 FSM states: IDLE, COLLECT, VEND, CHANGE; all outputs are registered.
REQ-021 IDLE: credit is 0. An accepted coin adds its value and moves to COLLECT. sel_valid pulses sel_err. cancel is ignored.
REQ-022 COLLECT, priority cancel > sel_valid > coin_valid; a lower-priority coin arriving in the same cycle is rejected with coin_reject.
REQ-023 COLLECT + cancel -> CHANGE with credit unchanged.
REQ-024 COLLECT + sel_valid: if sel_id < NUM_PROD, credit >= price and product in stock -> VEND; otherwise sel_err pulses and the FSM stays in COLLECT.
REQ-025 Coin acceptance: credit + value <= MAX_CREDIT and coin_val valid; otherwise coin_reject pulses and credit is unchanged.
REQ-026 VEND lasts exactly one cycle: vend_valid = 1, vend_id = latched selection, credit -= price; next state is CHANGE if the remaining credit > 0, else IDLE.
REQ-027 CHANGE: each cycle change_valid = 1 and credit -= 5; when credit reaches 0 the FSM moves to IDLE in the same transition.
REQ-028 Change for residual credit C takes C/5 consecutive cycles.
REQ-029 In VEND and CHANGE: coins are rejected (coin_reject), sel_valid is ignored, cancel is ignored.
REQ-030 Latency: sel_valid at edge N -> vend_valid at edge N+1 -> first change_valid at edge N+2.
REQ-031 Credit arithmetic is unsigned and never wraps; credit is always a multiple of 5 and <= MAX_CREDIT.

Reset
REQ-032 rst_n low asynchronously forces IDLE, credit = 0, and all pulse outputs, vend_id and busy = 0.
REQ-033 Reset mid-VEND or mid-CHANGE discards credit; no residual change is paid after release.
REQ-034 The first state update after release occurs on the first rising clk edge with rst_n high.

Configuration
REQ-035 Macro VENDING_STOCK_COUNT_EN.
  - Defined: per-product stock counter, loaded with STOCK_INIT on reset, decremented in VEND. Selecting a product at 0 stock pulses sel_err.
  - Undefined: no counters; every product is always in stock.

Verification
REQ-036 Reset, coin 10 then coin 5, select id 1 (price 10) -> credit 15, vend_valid with vend_id = 1, then one change_valid pulse, IDLE, credit 0.
REQ-037 Credit 35, coin 10 -> coin_reject, credit stays 35. Then cancel -> 7 consecutive change_valid pulses.
REQ-038 Credit 10, select id 3 (price 20) -> sel_err, state stays COLLECT, credit 10. Then select id 0 -> vend_id 0, one change_valid pulse.
REQ-039 Same-cycle cancel + sel_valid + coin in COLLECT with credit 10 -> coin_reject, no vend, 2 change_valid pulses.
REQ-040 rst_n asserted during the 2nd change pulse of a 20-unit refund -> outputs zero immediately, no further change_valid after release.
REQ-041 VENDING_STOCK_COUNT_EN defined, STOCK_INIT = 3: four buys of id 2 with exact credit 15 -> 3 vends, the 4th pulses sel_err, credit remains 15.
